// File: rtl/pc_update.sv
// Program-counter update and commit-status stage for a Y86-64-style sequential core.
// Selects the next PC, tracks the sticky machine status, and counts cycles and committed instructions.
module pc_update #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step_en,
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic [63:0] valM,
  input  logic        imem_error,
  input  logic        dmem_error,
  input  logic        instr_valid,
  input  logic        hlt,
  output logic [63:0] PC,
  output logic [2:0]  stat,
  output logic        halted,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] IC_HALT = 4'h0;
  localparam logic [3:0] IC_JXX  = 4'h7;
  localparam logic [3:0] IC_CALL = 4'h8;
  localparam logic [3:0] IC_RET  = 4'h9;
  localparam logic [3:0] IC_MAX  = 4'hB;

  // cnd only matters for conditional jumps; ret takes its target from the stack read.
  function automatic logic [63:0] calc_next_pc(
    input logic [3:0]  ic,
    input logic        c,
    input logic [63:0] vc,
    input logic [63:0] vp,
    input logic [63:0] vm
  );
    logic [63:0] npc;
    case (ic)
      IC_CALL: npc = vc;
      IC_JXX:  npc = c ? vc : vp;
      IC_RET:  npc = vm;
      default: npc = vp;
    endcase
    return npc;
  endfunction

  function automatic logic [2:0] calc_next_stat(
    input logic [3:0] ic,
    input logic       ierr,
    input logic       derr,
    input logic       ivld,
    input logic       h
  );
    logic [2:0] ns;
    if (ierr || derr) begin
      ns = STAT_ADR;
    end else if (!ivld || (ic > IC_MAX)) begin
      ns = STAT_INS;
    end else if (h || (ic == IC_HALT)) begin
      ns = STAT_HLT;
    end else begin
      ns = STAT_AOK;
    end
    return ns;
  endfunction

  logic [63:0] pc_q, pc_d;
  logic [2:0]  stat_q, stat_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic [63:0] next_pc_s;
  logic [2:0]  next_stat_s;

  assign next_pc_s   = calc_next_pc(icode, cnd, valC, valP, valM);
  assign next_stat_s = calc_next_stat(icode, imem_error, dmem_error, instr_valid, hlt);

  // Next-state: everything freezes once status leaves AOK; a faulting commit keeps its own PC.
  always_comb begin
    pc_d          = pc_q;
    stat_d        = stat_q;
    cycle_count_d = cycle_count_q;
    instr_count_d = instr_count_q;
    if (stat_q == STAT_AOK) begin
      cycle_count_d = cycle_count_q + 32'd1;
      if (step_en) begin
        stat_d        = next_stat_s;
        instr_count_d = instr_count_q + 32'd1;
        if (next_stat_s == STAT_AOK) begin
          pc_d = next_pc_s;
        end else begin
          pc_d = pc_q;
        end
      end else begin
        stat_d = stat_q;
      end
    end else begin
      stat_d = stat_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      stat_q        <= STAT_AOK;
      cycle_count_q <= 32'd0;
      instr_count_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      stat_q        <= stat_d;
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign PC          = pc_q;
  assign stat        = stat_q;
  assign halted      = (stat_q != STAT_AOK);
  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;

endmodule
